i2c_master_wr: RTL and testbench

// - I2C initiator that writes one data byte to the i2c_srg slave; it is the far end of the slave receive path.
// - Frame: START, 7-bit address + R/W=0, ACK slot, 8 data bits, ACK slot, STOP.
// - Bits go out MSB first on open-drain SCL/SDA.
// - Used by the filter testbench and by the on-chip config loader to program the slave.

---
 rtl/i2c_master_wr.sv | 159 +++++++++++++++
 tb/tb_i2c_master_wr.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write initiator: START, address+W, ACK, data byte, ACK, STOP.
// Line levels are registered and change only on quarter-period boundaries.
module i2c_master_wr #(
    parameter int          QDIV = 4,
    parameter logic [6:0]  ADDR = 7'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_in,
    input  logic [7:0] data_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       nack_out
);
    localparam int QW = (QDIV > 2) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
    } state_t;

    state_t          r_state;
    logic [QW-1:0]   r_q;
    logic [1:0]      r_ph;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_ack;
    logic            r_scl;
    logic            r_sda;
    logic            r_busy;
    logic            r_done;
    logic            r_nack;

    logic            w_wrap;
    logic            w_slot_end;

    assign w_wrap     = (r_q == QW'(QDIV - 1));
    assign w_slot_end = w_wrap && (r_ph == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_ph    <= 2'd0;
            r_bit   <= 3'd7;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_ack   <= 1'b1;
            r_scl   <= 1'b1;
            r_sda   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                r_q  <= '0;
                r_ph <= 2'd0;
                // A request coinciding with the done pulse is deliberately dropped.
                if (start_in && !r_done) begin
                    r_state <= S_START;
                    r_busy  <= 1'b1;
                    r_data  <= data_in;
                    r_nack  <= 1'b0;
                end
            end else begin
                r_q <= w_wrap ? '0 : r_q + 1'b1;
                if (w_wrap) begin
                    r_ph <= r_ph + 2'd1;
                end
                if (w_wrap && r_ph == 2'd1) begin
                    r_scl <= 1'b1;
                    if (r_state == S_START) begin
                        r_sda <= 1'b0;
                    end
                end
                if (w_wrap && r_ph == 2'd2) begin
                    if (r_state == S_STOP) begin
                        r_sda <= 1'b1;
                    end
                    if (r_state == S_AACK || r_state == S_DACK) begin
                        r_ack <= sda_in;
                    end
                end
                if (w_slot_end) begin
                    r_scl <= (r_state == S_STOP);
                    // r_shift holds the bits still to send after the one on the wire.
                    case (r_state)
                        S_START: begin
                            r_state <= S_ADDR;
                            r_bit   <= 3'd7;
                            r_sda   <= ADDR[6];
                            r_shift <= {ADDR[5:0], 2'b00};
                        end
                        S_ADDR: begin
                            if (r_bit == 3'd0) begin
                                r_state <= S_AACK;
                                r_sda   <= 1'b1;
                            end else begin
                                r_bit   <= r_bit - 3'd1;
                                r_sda   <= r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                        S_AACK: begin
                            if (r_ack) begin
                                r_state <= S_STOP;
                                r_nack  <= 1'b1;
                                r_sda   <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                                r_bit   <= 3'd7;
                                r_sda   <= r_data[7];
                                r_shift <= {r_data[6:0], 1'b0};
                            end
                        end
                        S_DATA: begin
                            if (r_bit == 3'd0) begin
                                r_state <= S_DACK;
                                r_sda   <= 1'b1;
                            end else begin
                                r_bit   <= r_bit - 3'd1;
                                r_sda   <= r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                        S_DACK: begin
                            r_state <= S_STOP;
                            r_sda   <= 1'b0;
                            if (r_ack) begin
                                r_nack <= 1'b1;
                            end
                        end
                        S_STOP: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_sda   <= 1'b1;
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_sda   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign scl_out  = r_scl;
    assign sda_out  = r_sda;
    assign busy_out = r_busy;
    assign done_out = r_done;
    assign nack_out = r_nack;
endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: a bus monitor/slave decodes SCL/SDA and checks bytes
// against a scoreboard queue filled when each frame is launched.
module tb_i2c_master_wr;
    localparam int         QDIV     = 4;
    localparam logic [6:0] TB_ADDR  = 7'h5A;
    localparam int         LAT_ACK  = 1 + 80 * QDIV;
    localparam int         LAT_NACK = 1 + 44 * QDIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       sda_in;
    logic       scl_out, sda_out, busy_out, done_out, nack_out;
    logic       slave_sda = 1'b1;

    assign sda_in = sda_out & slave_sda;

    i2c_master_wr #(.QDIV(QDIV), .ADDR(TB_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .data_in(data_in),
        .sda_in(sda_in), .scl_out(scl_out), .sda_out(sda_out),
        .busy_out(busy_out), .done_out(done_out), .nack_out(nack_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus monitor and ACKing slave model
    logic [7:0] exp_q[$];
    bit   ack_a_cfg = 1'b1, ack_d_cfg = 1'b1;
    int   mon_cnt = 0, starts = 0, stops = 0, bytes_seen = 0;
    logic [7:0] mon_sh = 8'h00;
    logic prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk) begin
        logic bus;
        logic [7:0] nb;
        if (!rst_n) begin
            mon_cnt   = 0;
            slave_sda = 1'b1;
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
        end else begin
            bus = sda_out & slave_sda;
            if (prev_scl && scl_out) begin
                if (prev_sda && !bus) begin
                    starts++;
                    mon_cnt = 0;
                end
                if (!prev_sda && bus) stops++;
            end
            if (!prev_scl && scl_out) begin
                nb = {mon_sh[6:0], bus};
                if (mon_cnt < 8 || (mon_cnt >= 9 && mon_cnt < 17)) mon_sh = nb;
                if (mon_cnt == 7 || mon_cnt == 16) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
                    end else begin
                        chk(mon_cnt == 7 ? "addr_byte" : "data_byte", 32'(nb), 32'(exp_q.pop_front()));
                    end
                    bytes_seen++;
                end
                mon_cnt++;
            end
            if (prev_scl && !scl_out) begin
                if (mon_cnt == 8)  slave_sda = ack_a_cfg ? 1'b0 : 1'b1;
                if (mon_cnt == 17) slave_sda = ack_d_cfg ? 1'b0 : 1'b1;
                if (mon_cnt == 9 || mon_cnt == 18) slave_sda = 1'b1;
            end
            prev_scl = scl_out;
            prev_sda = sda_out & slave_sda;
        end
    end

    task automatic launch(input logic [7:0] d, input bit aa, input bit ad, output int t0);
        ack_a_cfg  = aa;
        ack_d_cfg  = ad;
        starts     = 0;
        stops      = 0;
        bytes_seen = 0;
        exp_q.push_back({TB_ADDR, 1'b0});
        if (aa) exp_q.push_back(d);
        data_in  = d;
        start_in = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_in = 1'b0;
        data_in  = 8'h00;
        chk("busy_after_accept", 32'(busy_out), 32'd1);
    endtask

    task automatic finish_frame(input int t0, input int exp_lat, input bit exp_nack,
                                input int exp_bytes, input bit mid, input logic [7:0] d);
        bit got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_out) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            if (mid && cyc == t0 + 150) begin
                start_in = 1'b1;
                data_in  = 8'h3C;
            end else begin
                start_in = 1'b0;
            end
        end
        start_in = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", 32'(cyc - t0), 32'(exp_lat));
        chk("nack", 32'(nack_out), 32'(exp_nack));
        chk("busy_low_at_done", 32'(busy_out), 32'd0);
        chk("bytes_seen", 32'(bytes_seen), 32'(exp_bytes));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("start_cond", 32'(starts), 32'd1);
        chk("stop_cond", 32'(stops), 32'd1);
        $display("frame data=%02h lat=%0d nack=%0b bytes=%0d", d, cyc - t0, nack_out, bytes_seen);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack_a;
        bit         ack_d;
        bit         exp_nack;
        int         exp_lat;
        int         exp_bytes;
        bit         mid;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0;
        bit hit;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, LAT_ACK,  2, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, LAT_ACK,  2, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, LAT_ACK,  2, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 1'b1, LAT_NACK, 1, 1'b0};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b0, LAT_ACK,  2, 1'b1};

        rst_n = 1'b0;
        repeat (50) @(negedge clk);
        chk("rst_scl", 32'(scl_out), 32'd1);
        chk("rst_sda", 32'(sda_out), 32'd1);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_nack", 32'(nack_out), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            launch(vecs[v].data, vecs[v].ack_a, vecs[v].ack_d, t0);
            finish_frame(t0, vecs[v].exp_lat, vecs[v].exp_nack, vecs[v].exp_bytes,
                         vecs[v].mid, vecs[v].data);
            repeat (2) @(negedge clk);
        end

        // Request raised in the done cycle is dropped, then taken one cycle later.
        launch(8'h96, 1'b1, 1'b1, t0);
        finish_frame(t0, LAT_ACK, 1'b0, 2, 1'b0, 8'h96);
        start_in = 1'b1;
        data_in  = 8'h81;
        @(negedge clk);
        chk("start_at_done_ignored", 32'(busy_out), 32'd0);
        launch(8'h81, 1'b1, 1'b1, t0);
        finish_frame(t0, LAT_ACK, 1'b0, 2, 1'b0, 8'h81);
        repeat (2) @(negedge clk);

        // Asynchronous reset during data bit 3, then a clean frame.
        launch(8'hA5, 1'b1, 1'b1, t0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mon_cnt == 13 && !scl_out) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_data_bit3", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_scl", 32'(scl_out), 32'd1);
        chk("abort_sda", 32'(sda_out), 32'd1);
        chk("abort_busy", 32'(busy_out), 32'd0);
        $display("reset asserted mid-frame at cycle %0d", cyc);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_done", 32'(done_out), 32'd0);
        launch(8'hC3, 1'b1, 1'b1, t0);
        finish_frame(t0, LAT_ACK, 1'b0, 2, 1'b0, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
